// File: rtl/uart_tx_frame_p.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_p
// Description : Parametrised UART transmit engine. The FSM, serializer, parity
//               generator and output mux live in one block. A frame is
//               start bit, DATA_W payload bits (LSB first), an optional
//               even/odd parity bit and one or two stop bits. Frames can run
//               back to back with no idle gap between them.
// Ports       : clk        - single clock for all logic
//               rst        - synchronous, active-high reset
//               p_data     - parallel payload, LSB transmitted first
//               data_valid - request to send p_data, accepted when ready=1
//               par_en     - 1 = insert parity bit after the data
//               par_typ    - 0 = even parity, 1 = odd parity
//               stop2      - 0 = one stop bit, 1 = two stop bits
//               ready      - a frame can be accepted this cycle
//               busy       - frame in progress
//               frame_done - one-cycle pulse in the final clk of the last stop bit
//               tx_out     - registered serial line, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_p #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] p_data,
    input  logic              data_valid,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              stop2,
    output logic              ready,
    output logic              busy,
    output logic              frame_done,
    output logic              tx_out
);

    localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BW = $clog2(DATA_W);

    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_W - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]        r_state;
    logic [c_CW-1:0]   r_baud_cnt;
    logic [c_BW-1:0]   r_bit_cnt;
    logic              r_stop_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_par_en;
    logic              r_par_typ;
    logic              r_stop2;
    logic              r_tx;

    logic [2:0]        w_state_nxt;
    logic [c_CW-1:0]   w_baud_nxt;
    logic [c_BW-1:0]   w_bit_nxt;
    logic              w_stop_nxt;
    logic              w_tx_nxt;
    logic              w_bit_end;
    logic              w_last_stop;
    logic              w_accept;

    assign w_bit_end   = (r_baud_cnt == c_BAUD_LAST);
    assign w_last_stop = (r_state == c_STOP) && w_bit_end && (r_stop_cnt == r_stop2);
    assign w_accept    = data_valid & ready;
    assign tx_out      = r_tx;

    // ------------------------------------------------------------------------
    // State, counters, config latches and the registered serial line
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        assert (DATA_W >= 5 && DATA_W <= 9 && CLKS_PER_BIT >= 1)
            else $error("uart_tx_frame_p: unsupported parameters DATA_W=%0d CLKS_PER_BIT=%0d",
                        DATA_W, CLKS_PER_BIT);
        if (rst) begin
            r_state    <= c_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_tx       <= w_tx_nxt;
            if (w_accept) begin
                r_data    <= p_data;
                r_par_en  <= par_en;
                r_par_typ <= par_typ;
                r_stop2   <= stop2;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_stop_nxt  = r_stop_cnt;

        // The baud counter free-runs through every bit of a frame and wraps
        // at each bit boundary, so back-to-back frames start at zero too.
        if (r_state != c_IDLE) begin
            w_baud_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
        end

        case (r_state)
            c_IDLE: begin
                if (w_accept) w_state_nxt = c_START;
            end
            c_START: begin
                if (w_bit_end) w_state_nxt = c_DATA;
            end
            c_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = r_par_en ? c_PARITY : c_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            c_PARITY: begin
                if (w_bit_end) w_state_nxt = c_STOP;
            end
            c_STOP: begin
                if (w_bit_end) begin
                    if (w_last_stop) begin
                        w_stop_nxt  = 1'b0;
                        w_state_nxt = w_accept ? c_START : c_IDLE;
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs. The serial value is chosen from the *next* state so that the
    // registered line changes on the same edge as the state.
    // ------------------------------------------------------------------------
    always_comb begin
        busy       = (r_state != c_IDLE);
        ready      = (r_state == c_IDLE) || w_last_stop;
        frame_done = w_last_stop;

        // DATA is only ever entered from START, so r_data is already latched
        // for the current frame whenever it is read here.
        case (w_state_nxt)
            c_START:  w_tx_nxt = 1'b0;
            c_DATA:   w_tx_nxt = r_data[w_bit_nxt];
            c_PARITY: w_tx_nxt = (^r_data) ^ r_par_typ;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame_p.md
Name: uart_tx_frame_p

Overview:
Parametrised UART transmit engine: next generation of the TX controller. It combines the FSM, serializer, parity generator and output mux in one block, with configurable data width and bit period. It adds runtime parity type (even/odd), 1 or 2 stop bits, and back-to-back frames with no idle gap. It sits between the system register file/FIFO read side and the TX pin.

Parameters:
DATA_W, 8, payload bits per frame; legal range 5..9
CLKS_PER_BIT, 1, clk cycles per transmitted bit (baud divider); legal range >=1

Ports:
clk  input  1  single clock for all logic
rst  input  1  synchronous, active-high reset
p_data  input  DATA_W  parallel payload; LSB transmitted first
data_valid  input  1  request to send p_data; accepted when ready=1
par_en  input  1  1 = insert parity bit after data
par_typ  input  1  0 = even parity, 1 = odd parity
stop2  input  1  0 = one stop bit, 1 = two stop bits
ready  output  1  block can accept a frame this cycle (combinational from state/counters)
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse in the final clk of the last stop bit
tx_out  output  1  serial line, registered, idles high

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, tx_out=1, busy=0, frame_done=0, all counters=0, data/config latches=0. Reset mid-frame abandons the frame: tx_out=1 from the next edge, no frame_done.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is free; busy=1 in all states except IDLE.
- Accept: accept = data_valid & ready. On accept, latch p_data, par_en, par_typ and stop2. Input changes after accept have no effect on the current frame.
- ready=1 in IDLE, and in the final clk of the last stop bit (back-to-back case). Otherwise ready=0.
- Bit timing: baud_cnt counts 0..CLKS_PER_BIT-1. A bit ends when baud_cnt=CLKS_PER_BIT-1, then baud_cnt wraps to 0. With CLKS_PER_BIT=1 every bit lasts one clk.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA at bit end.
  - DATA: bit_cnt counts 0..DATA_W-1. At bit end with bit_cnt=DATA_W-1, go to PARITY if latched par_en=1, else STOP.
  - PARITY -> STOP at bit end.
  - STOP: stop_cnt counts 0..stop2. At end of the last stop bit, go to START if accept occurs that cycle, else IDLE.
- tx_out values:
  - IDLE = 1.
  - START = 0.
  - DATA = latched data[bit_cnt].
  - PARITY = (^data) XOR par_typ.
  - STOP = 1.
  - tx_out is registered: state entered at edge k drives tx_out from edge k, for exactly CLKS_PER_BIT cycles per bit.
- Latency: accept sampled at edge k; start bit visible on tx_out after edge k (same edge as the state change).
- Frame length = CLKS_PER_BIT*(1 + DATA_W + par_en + 1 + stop2) clk cycles.
  - Back-to-back frames abut with no idle cycle between them.
  - Non-back-to-back frames get at least one IDLE cycle between them.
- Simultaneous events:
  - data_valid held high while busy, outside the accept cycle, is ignored.
  - rst has priority over accept.
- frame_done asserts exactly once per completed frame, in the same cycle as the back-to-back ready window.
- No X on any output after reset. Parameter values outside the legal range are not supported; a simulation-only assertion flags them.

Test Plan:
- DATA_W=8, CPB=1, p_data=0xA5, par_en=1, par_typ=0, stop2=0 -> tx_out over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; frame_done pulses in cycle 11; busy=1 for cycles 1..11.
- Same data with par_typ=1, stop2=1 -> parity bit=1; two stop bits; 12-cycle frame; p_data changed to 0xFF mid-frame has no effect.
- CPB=4, p_data=0x01, par_en=0 -> each bit held 4 cycles; 40-cycle frame; first data bit=1, others 0; ready=0 until the final stop cycle.
- Back-to-back: data_valid held high with 0x3C then 0xC3, CPB=1, par_en=0 -> second start bit immediately follows the first stop bit; no idle-high gap; frame_done pulses twice, 10 cycles apart.
- Reset mid-frame: rst=1 during DATA bit 3 -> next edge tx_out=1, busy=0, ready=1, no frame_done; the next accepted frame is transmitted cleanly.
- DATA_W=5, CPB=2, p_data=5'b10110, par_en=1, par_typ=1 -> parity bit=0 (three ones, odd); 16-cycle frame.
